// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, buffers {pc, instr} pairs in a circular queue, hands them to decode.
// Define FETCHQ_BYPASS_EN to let a word fetched into an empty queue reach decode in the same cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [31:0]             imem_addr,
    input  logic [31:0]             imem_rdata,
    input  logic                    imem_ready,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_pc,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];

    logic pop;
    logic space;
    logic push;
    logic bypass;
    logic write_en;
    logic queue_pop;
    logic unused_rpc_lsb;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = (level_q == '0) & imem_ready & ~redirect;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = (level_q != '0) | bypass;
    assign out_instr = bypass ? imem_rdata : instr_q[rd_ptr];
    assign out_pc    = bypass ? fetch_pc   : pc_q[rd_ptr];

    assign pop   = out_valid & out_ready;
    assign space = (level_q < FULL) | pop;
    assign push  = imem_ready & space & ~redirect;

    // A bypassed word that decode takes right away never occupies a slot.
    assign write_en  = push & ~(bypass & out_ready);
    assign queue_pop = pop & ~bypass;

    assign imem_addr      = fetch_pc;
    assign level          = level_q;
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    always_comb begin
        level_d = level_q;
        if (write_en && !queue_pop) begin
            level_d = level_q + LW'(1);
        end else if (queue_pop && !write_en) begin
            level_d = level_q - LW'(1);
        end
    end

    // Redirect wins over push; a pop in that cycle was already delivered to decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (write_en) begin
                pc_q[wr_ptr]    <= fetch_pc;
                instr_q[wr_ptr] <= imem_rdata;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (queue_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4, default build without bypass).
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  level;

    int tests;
    int failed;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .level       (level)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word i holds 32'h1000_0000 + i.
    assign imem_rdata = 32'h1000_0000 + (imem_addr >> 2);

    task automatic applyStimulus(input logic ir, input logic ordy, input logic redir,
                                 input logic [31:0] rpc);
        imem_ready  = ir;
        out_ready   = ordy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b0;
        nextCycle;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        ir_pat   [6];
        logic [31:0] addr_exp [6];
        logic [31:0] got_pc   [4];
        int          delivered;

        tests  = 0;
        failed = 0;

        // Reset state
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle;
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_level", {29'b0, level}, 32'd0);
        checkOutput("rst_addr", imem_addr, RESET_PC);
        checkOutput("rst_pc", out_pc, 32'd0);
        checkOutput("rst_instr", out_instr, 32'd0);

        // Streaming: one entry per cycle, first valid one cycle after release
        rst = 1'b1;
        #1;
        checkOutput("stream_first_invalid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            nextCycle;
            checkOutput("stream_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stream_pc", out_pc, 32'(4 * i));
            checkOutput("stream_instr", out_instr, 32'h1000_0000 + 32'(i));
        end

        // Fill to full with decode stalled, then drain with simultaneous push
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        doReset;
        checkOutput("fill_level0", {29'b0, level}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            nextCycle;
            if (k == 4 || k == 6) begin
                checkOutput("fill_level_full", {29'b0, level}, 32'd4);
                checkOutput("fill_addr_stop", imem_addr, 32'h10);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("drain_pc0", out_pc, 32'h0);
        checkOutput("drain_level", {29'b0, level}, 32'd4);
        checkOutput("drain_addr_resume", imem_addr, 32'h10);
        for (int j = 1; j <= 5; j++) begin
            nextCycle;
            checkOutput("drain_level_hold", {29'b0, level}, 32'd4);
            checkOutput("drain_pc", out_pc, 32'(4 * j));
            checkOutput("drain_addr", imem_addr, 32'h10 + 32'(4 * j));
        end
        checkOutput("drain_instr", out_instr, 32'h1000_0005);

        // Redirect with 3 entries queued; low address bits dropped
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        doReset;
        nextCycle;
        nextCycle;
        nextCycle;
        checkOutput("redir_pre_level", {29'b0, level}, 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        nextCycle;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_level", {29'b0, level}, 32'd0);
        checkOutput("redir_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("redir_addr", imem_addr, 32'h100);
        nextCycle;
        checkOutput("redir_new_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("redir_new_pc", out_pc, 32'h100);
        checkOutput("redir_new_instr", out_instr, 32'h1000_0040);

        // Fetch PC wrap at the top of the address space
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        nextCycle;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_level0", {29'b0, level}, 32'd0);
        nextCycle;
        checkOutput("wrap_addr_zero", imem_addr, 32'h0);
        checkOutput("wrap_pc", out_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_instr", out_instr, 32'h4FFF_FFFF);
        checkOutput("wrap_level1", {29'b0, level}, 32'd1);

        // imem_ready pattern 1,0,0,1 then idle, decode always ready
        ir_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        addr_exp = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h8, 32'h8};
        delivered = 0;
        got_pc    = '{32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD};
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        doReset;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ir_pat[i], 1'b1, 1'b0, 32'h0);
            checkOutput("stall_addr", imem_addr, addr_exp[i]);
            if (out_valid === 1'b1) begin
                if (delivered < 4) got_pc[delivered] = out_pc;
                delivered++;
            end
            nextCycle;
        end
        checkOutput("stall_delivered", 32'(delivered), 32'd2);
        checkOutput("stall_pc0", got_pc[0], 32'h0);
        checkOutput("stall_pc1", got_pc[1], 32'h4);

        // Asynchronous reset mid-operation with 2 entries queued
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        doReset;
        nextCycle;
        nextCycle;
        checkOutput("areset_pre_level", {29'b0, level}, 32'd2);
        checkOutput("areset_pre_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("areset_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("areset_level", {29'b0, level}, 32'd0);
        checkOutput("areset_addr", imem_addr, RESET_PC);
        nextCycle;
        rst = 1'b1;
        #1;
        checkOutput("areset_release_addr", imem_addr, RESET_PC);
        checkOutput("areset_release_level", {29'b0, level}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage between the PC/instruction-memory pair and the decode/register-file/extender stage.
- Owns the fetch PC and drives the instruction-memory address.
- Buffers fetched {pc, instruction} pairs in a small circular queue.
- Presents the pairs to decode with a valid/ready handshake.
- Taken branches and jumps arrive as a redirect that flushes the queue and restarts fetch.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h00000000, fetch PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- imem_addr  output  32  byte address to instruction memory; combinationally equal to fetch_pc.
- imem_rdata  input  32  instruction word returned for imem_addr.
- imem_ready  input  1  imem_rdata is valid this cycle; tie to 1 for combinational memory.
- redirect  input  1  single-cycle request to flush and restart fetch.
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode accepts the head entry.
- out_instr  output  32  head instruction.
- out_pc  output  32  address of the head instruction.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc = RESET_PC; rd_ptr = wr_ptr = level = 0; all entries cleared to 0.
  - out_valid = 0, out_instr = 0, out_pc = 0, imem_addr = RESET_PC.
  - A reset asserted mid-operation discards all queued entries immediately.
- Definitions:
  - pop = out_valid & out_ready.
  - space = (level < DEPTH) | pop. A full queue accepts a push in the same cycle as a pop.
  - push = imem_ready & space & ~redirect.
- Push: write {fetch_pc, imem_rdata} at wr_ptr; wr_ptr += 1 modulo DEPTH; fetch_pc += 4.
- Fetch PC wrap: fetch_pc wraps from 32'hFFFFFFFC to 0 with no flag.
- Pop: rd_ptr += 1 modulo DEPTH.
- Occupancy update:
  - level += 1 on push without pop.
  - level -= 1 on pop without push.
  - level is unchanged on both or neither.
- Outputs (no bypass): out_valid = (level != 0); out_instr/out_pc come from entry rd_ptr. out_instr/out_pc are don't-care while out_valid = 0.
- Latency: an instruction fetched in cycle N is first presented as out_valid in cycle N+1.
- Redirect has the highest priority. In the cycle redirect = 1:
  - No push happens.
  - A handshaked pop still counts as delivered to decode.
  - At the edge: level = 0, rd_ptr = wr_ptr = 0, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - First instruction from the new path is out_valid two cycles after the redirect cycle.
- imem_ready = 0: no push, fetch_pc holds, imem_addr holds; pop still allowed.
- Empty with out_ready = 1: no pop; out_valid stays 0.
- Ordering: entries always leave in fetch order; no entry is duplicated or dropped except by redirect or reset.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined, when level = 0 and imem_ready = 1 and redirect = 0:
  - out_valid = 1 in the same cycle, with out_instr = imem_rdata and out_pc = fetch_pc.
  - If out_ready = 1, the word is consumed without being written to the queue: level stays 0, fetch_pc += 4.
  - If out_ready = 0, it is pushed normally.
  - Zero-cycle fetch-to-decode latency.
- Not defined: out_valid depends only on level; minimum latency is 1 cycle.
- All other behaviour is identical in both builds.

Test Plan:
- Reset release, imem_ready = 1, out_ready = 1, memory word[i] = 32'h1000_0000 + i:
  - out_pc runs 0, 4, 8, … and out_instr runs 32'h10000000, 32'h10000001, … on consecutive cycles.
  - First out_valid one cycle after reset release.
- out_ready = 0 for 6 cycles from empty:
  - level reaches 4 (DEPTH = 4) and holds.
  - imem_addr stops at 32'h10.
  - Then out_ready = 1: entries with pc 0, 4, 8, C drain in order, and fetch resumes at 32'h10.
- Full queue with out_ready = 1 and imem_ready = 1 in the same cycle: level stays 4, one pop and one push occur, and the pc sequence has no gap.
- Queue holding 3 entries, redirect = 1 with redirect_pc = 32'h0000_0103:
  - Next cycle level = 0, out_valid = 0, imem_addr = 32'h100.
  - The cycle after, out_pc = 32'h100.
- imem_ready toggling 1,0,0,1 with out_ready = 1: exactly two entries are delivered, pcs 0 and 4; imem_addr holds 4 while imem_ready = 0.
- Reset pulled low while level = 2:
  - out_valid = 0 and level = 0 before the next clock edge.
  - After release, imem_addr = RESET_PC.
